// File: rtl/pixel_scheduler.sv
// Pixel scheduler: hands raster-ordered pixel coordinates round-robin to NUM_LANES
// ray-march lanes, then gathers their shades back in the same order into one
// registered RGB888 output stream with start-of-frame / end-of-line markers.
// Optional feature: define SCHED_CONTINUOUS_EN to regenerate frames back to back
// (DONE goes straight to RUN) instead of waiting for start in IDLE.
module pixel_scheduler #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    frame_done,
    output logic [9:0]              disp_x,
    output logic [8:0]              disp_y,
    output logic [NUM_LANES-1:0]    disp_valid,
    input  logic [NUM_LANES-1:0]    disp_ready,
    input  logic [24*NUM_LANES-1:0] res_data,
    input  logic [NUM_LANES-1:0]    res_valid,
    output logic [NUM_LANES-1:0]    res_ready,
    output logic [23:0]             out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sof,
    output logic                    out_eol
);

    localparam int unsigned LaneW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [LaneW-1:0] LastLane = LaneW'(NUM_LANES - 1);
    localparam logic [9:0]       LastX    = 10'(H_RES - 1);
    localparam logic [8:0]       LastY    = 9'(V_RES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e state_q, state_d;

    // Dispatch side
    logic [9:0]       dx_q;
    logic [8:0]       dy_q;
    logic [LaneW-1:0] dlane_q;

    // Collect side; cx/cy track the raster position of the next result to accept
    logic [9:0]       cx_q;
    logic [8:0]       cy_q;
    logic [LaneW-1:0] clane_q;
    logic             coll_done_q;

    // Output register
    logic [23:0] out_data_q;
    logic        out_valid_q;
    logic        out_sof_q;
    logic        out_eol_q;
    logic        out_last_q;

    logic        run;
    logic        collecting;
    logic        disp_fire;
    logic        disp_last;
    logic        res_fire;
    logic        coll_last;
    logic        out_fire;
    logic        out_free;
    logic [23:0] res_pick;

    assign disp_fire = |(disp_valid & disp_ready);
    assign disp_last = (dx_q == LastX) && (dy_q == LastY);
    assign res_fire  = |(res_valid & res_ready);
    assign coll_last = (cx_q == LastX) && (cy_q == LastY);
    assign out_fire  = out_valid_q && out_ready;
    assign out_free  = !out_valid_q || out_ready;
    assign res_pick  = res_data[24*clane_q +: 24];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (disp_fire && disp_last) state_d = StDrain;
            StDrain: if (out_fire && out_last_q) state_d = StDone;
`ifdef SCHED_CONTINUOUS_EN
            StDone:  state_d = StRun;
`else
            StDone:  state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    // FSM-derived outputs and one-hot lane selects
    always_comb begin
        run        = (state_q == StRun);
        collecting = (state_q == StRun) || (state_q == StDrain);
        busy       = collecting;
        frame_done = (state_q == StDone);
        disp_valid = '0;
        res_ready  = '0;
        if (run) begin
            disp_valid[dlane_q] = 1'b1;
        end
        // Accept only when the output slot frees up this cycle, giving pass-through rate
        if (collecting && !coll_done_q && out_free) begin
            res_ready[clane_q] = 1'b1;
        end
    end

    // Dispatch raster counters and lane pointer; cleared between frames
    always_ff @(posedge clk) begin
        if (rst || (state_q == StDone)) begin
            dx_q    <= '0;
            dy_q    <= '0;
            dlane_q <= '0;
        end else if (disp_fire) begin
            dlane_q <= (dlane_q == LastLane) ? '0 : dlane_q + LaneW'(1);
            if (dx_q == LastX) begin
                dx_q <= '0;
                dy_q <= (dy_q == LastY) ? '0 : dy_q + 9'd1;
            end else begin
                dx_q <= dx_q + 10'd1;
            end
        end
    end

    // Result collection in dispatch order and the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            cx_q        <= '0;
            cy_q        <= '0;
            clane_q     <= '0;
            coll_done_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (state_q == StDone) begin
                cx_q        <= '0;
                cy_q        <= '0;
                clane_q     <= '0;
                coll_done_q <= 1'b0;
            end
            if (res_fire) begin
                out_data_q  <= res_pick;
                out_valid_q <= 1'b1;
                out_sof_q   <= (cx_q == '0) && (cy_q == '0);
                out_eol_q   <= (cx_q == LastX);
                out_last_q  <= coll_last;
                clane_q     <= (clane_q == LastLane) ? '0 : clane_q + LaneW'(1);
                if (coll_last) begin
                    coll_done_q <= 1'b1;
                end
                if (cx_q == LastX) begin
                    cx_q <= '0;
                    cy_q <= (cy_q == LastY) ? '0 : cy_q + 9'd1;
                end else begin
                    cx_q <= cx_q + 10'd1;
                end
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
                out_sof_q   <= 1'b0;
                out_eol_q   <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign disp_x    = dx_q;
    assign disp_y    = dy_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;

endmodule
